// File: rtl/uart_rx_8n1_pkg.sv
// Shared definitions for the 8N1 UART receiver: receive FSM states and the
// default bit period, which also drives the board's clock generator setup.
package uart_rx_8n1_pkg;

    // 12 MHz system clock / 625 = 19200 baud
    localparam int DEFAULT_CLK_PER_BIT = 625;

    // Number of data bits in one 8N1 frame
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

    // Clocks from the start edge to the middle of the start bit
    function automatic int half_bit(input int clk_per_bit);
        return clk_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_8n1_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input. The reset value
// is a parameter so the same block can sit on idle-high lines (UART rx) and
// idle-low lines (buttons, interrupt pins).
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the raw input, then re-register to let metastability settle
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronises rx, validates the start bit at mid-bit,
// shifts in 8 data bits LSB first and checks the stop bit. Good frames update
// data with a one-cycle valid strobe; a low stop bit gives a frame_err strobe.
module uart_rx_8n1
    import uart_rx_8n1_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int HALF  = half_bit(CLK_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // rx is asynchronous to clk; every decision below uses rx_s only
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Next-state, counters, shift register and output strobes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Low line while idle is taken as a start edge
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                // Re-check at mid start bit to reject glitches
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                // Leaving at mid stop bit leaves half a bit of slack for a
                // back-to-back start edge
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                // A held-low (break) line must not look like a new start
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, output byte and strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Shift register holds only in-flight bits and is fully rewritten per frame
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Testbench for uart_rx_8n1 at 16 clocks per bit. Frames are driven on the rx
// pin; each expected outcome is queued when driven and checked when the DUT
// strobes valid or frame_err.
module tb_uart_rx_8n1;

    localparam int CPB   = 16;
    localparam int CLK_T = 10;
    localparam int BIT_T = CPB * CLK_T;

    typedef struct {
        logic       err;
        logic [7:0] b;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int   n_chk;
    int   n_pass;
    int   cyc;
    int   last_vcyc;
    logic [7:0] last_good;
    exp_t exp_q[$];
    int   vcyc_q[$];

    uart_rx_8n1 #(
        .CLK_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #(CLK_T / 2) clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic err);
        exp_t e;
        e.b   = b;
        e.err = err;
        exp_q.push_back(e);
    endtask

    // Drive start, 8 data bits LSB first and stop; leaves rx at the stop level
    task automatic send_frame(input logic [7:0] b, input int bit_t, input logic stop_bit);
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_t);
        end
        rx = stop_bit;
        #(bit_t);
    endtask

    // Scoreboard: compare every strobe against the oldest queued expectation
    always @(negedge clk) begin
        if (rst === 1'b0 && (valid === 1'b1 || frame_err === 1'b1)) begin
            exp_t e;
            chk("excl_valid_ferr", {31'd0, valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind_ferr", {31'd0, frame_err}, {31'd0, e.err});
                if (e.err) begin
                    chk("ferr_data_kept", {24'd0, data}, {24'd0, last_good});
                end else begin
                    chk("rx_data", {24'd0, data}, {24'd0, e.b});
                    last_good = e.b;
                    last_vcyc = cyc;
                    vcyc_q.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int busy_cnt;

        n_chk     = 0;
        n_pass    = 0;
        last_vcyc = -1;
        last_good = 8'h00;
        rst       = 1'b1;
        rx        = 1'b1;

        cycles(5);
        chk("rst_data", {24'd0, data}, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'h0);
        chk("rst_ferr", {31'd0, frame_err}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;
        cycles(5);

        // Single byte with exact strobe latency
        n0 = cyc;
        expect_byte(8'hA5, 1'b0);
        send_frame(8'hA5, BIT_T, 1'b1);
        cycles(5);
        chk("a5_latency", last_vcyc, n0 + 2 + CPB / 2 + 9 * CPB + 1);
        chk("a5_data_held", {24'd0, data}, 32'hA5);
        cycles(20);

        // Back-to-back with no idle gap
        vcyc_q.delete();
        expect_byte(8'h00, 1'b0);
        expect_byte(8'hFF, 1'b0);
        expect_byte(8'h55, 1'b0);
        send_frame(8'h00, BIT_T, 1'b1);
        send_frame(8'hFF, BIT_T, 1'b1);
        send_frame(8'h55, BIT_T, 1'b1);
        cycles(5);
        chk("b2b_count", vcyc_q.size(), 32'd3);
        if (vcyc_q.size() == 3) begin
            chk("b2b_gap1", vcyc_q[1] - vcyc_q[0], 32'd160);
            chk("b2b_gap2", vcyc_q[2] - vcyc_q[1], 32'd160);
        end
        cycles(20);

        // False start: 5-cycle low pulse
        rx = 1'b0;
        cycles(5);
        rx = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("false_start_busy_seen", {31'd0, busy_cnt > 0}, 32'd1);
        chk("false_start_busy_le9", {31'd0, busy_cnt <= 9}, 32'd1);
        chk("false_start_idle", {31'd0, busy}, 32'd0);
        cycles(5);
        expect_byte(8'h3C, 1'b0);
        send_frame(8'h3C, BIT_T, 1'b1);
        cycles(20);

        // Framing error followed by a break
        expect_byte(8'h81, 1'b1);
        send_frame(8'h81, BIT_T, 1'b0);
        cycles(40);
        chk("break_busy", {31'd0, busy}, 32'd1);
        chk("break_data_kept", {24'd0, data}, 32'h3C);
        rx = 1'b1;
        cycles(5);
        chk("break_exit_busy", {31'd0, busy}, 32'd0);
        cycles(5);
        expect_byte(8'h42, 1'b0);
        send_frame(8'h42, BIT_T, 1'b1);
        cycles(20);

        // Reset during data bit 4 of 0x99; sender aborts and idles the line
        rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            rx = ((8'h99 >> i) & 8'h01) != 8'h00;
            #(BIT_T);
        end
        rx = 1'b1;
        #(BIT_T / 2);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        last_good = 8'h00;
        cycles(1);
        rst = 1'b0;
        cycles(3);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_data", {24'd0, data}, 32'h0);
        cycles(200);
        expect_byte(8'h99, 1'b0);
        send_frame(8'h99, BIT_T, 1'b1);
        cycles(20);

        // Baud tolerance: -3% and +3% bit period
        expect_byte(8'hC3, 1'b0);
        send_frame(8'hC3, BIT_T - CLK_T / 2, 1'b1);
        cycles(20);
        expect_byte(8'hC3, 1'b0);
        send_frame(8'hC3, BIT_T + CLK_T / 2, 1'b1);
        cycles(20);
        chk("tol_data", {24'd0, data}, 32'hC3);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
